// File: rtl/dim_sequencer_if.sv
// Button/frame request inputs and brightness/colour outputs of dim_sequencer.
// master = requester side (debouncers, VGA timing, colour mux); slave = sequencer.
interface dim_sequencer_if;
    logic       btn_up;
    logic       btn_down;
    logic       btn_mode;
    logic       btn_color;
    logic       frame_start;
    logic [3:0] dim_level;
    logic [2:0] xhair_color;
    logic       fade_active;

    modport master (
        output btn_up, btn_down, btn_mode, btn_color, frame_start,
        input  dim_level, xhair_color, fade_active
    );

    modport slave (
        input  btn_up, btn_down, btn_mode, btn_color, frame_start,
        output dim_level, xhair_color, fade_active
    );
endinterface

// File: rtl/dim_sequencer.sv
// Brightness / crosshair colour sequencer; changes land only on frame boundaries.
// Optional macro DIM_GAMMA_EN maps the internal level through a gamma LUT.
module dim_sequencer #(
    parameter int FRAMES_PER_STEP = 4,
    parameter int HOLD_FRAMES     = 30
) (
    input  logic           clk,
    input  logic           rst,
    dim_sequencer_if.slave bus
);

    typedef enum logic [1:0] {MANUAL, FADE_DOWN, FADE_UP, HOLD} state_t;

    localparam int CNT_MAX = (FRAMES_PER_STEP > HOLD_FRAMES) ? FRAMES_PER_STEP : HOLD_FRAMES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(FRAMES_PER_STEP - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_FRAMES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t           state_q, state_nxt;
    logic [3:0]       level_q, level_nxt;
    logic [CNT_W-1:0] cnt_q, cnt_nxt;
    logic [2:0]       color_q;
    logic [3:0]       dim_q;
    logic             fade_q;
    logic             pend_up_q, pend_down_q, pend_mode_q, pend_color_q;
    logic             req_up, req_down, req_mode, req_color;

    function automatic logic [3:0] map_level(input logic [3:0] l);
`ifdef DIM_GAMMA_EN
        case (l)
            4'd0, 4'd1, 4'd2: map_level = 4'd0;
            4'd3, 4'd4, 4'd5: map_level = 4'd1;
            4'd6, 4'd7:       map_level = 4'd2;
            4'd8:             map_level = 4'd3;
            4'd9:             map_level = 4'd4;
            4'd10:            map_level = 4'd5;
            4'd11:            map_level = 4'd6;
            4'd12:            map_level = 4'd8;
            4'd13:            map_level = 4'd10;
            4'd14:            map_level = 4'd12;
            default:          map_level = 4'd15;
        endcase
`else
        map_level = l;
`endif
    endfunction

    // A pulse arriving together with frame_start is serviced in that same frame.
    assign req_up    = pend_up_q    | bus.btn_up;
    assign req_down  = pend_down_q  | bus.btn_down;
    assign req_mode  = pend_mode_q  | bus.btn_mode;
    assign req_color = pend_color_q | bus.btn_color;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= MANUAL;
        else if (bus.frame_start)
            state_q <= state_nxt;
    end

    always_comb begin
        state_nxt = state_q;
        level_nxt = level_q;
        cnt_nxt   = cnt_q;
        if (req_mode) begin
            cnt_nxt   = '0;
            state_nxt = (state_q == MANUAL) ? FADE_DOWN : MANUAL;
        end else begin
            case (state_q)
                MANUAL: begin
                    if (req_up && !req_down && level_q != 4'd15)
                        level_nxt = level_q + 4'd1;
                    else if (req_down && !req_up && level_q != 4'd0)
                        level_nxt = level_q - 4'd1;
                end
                FADE_DOWN: begin
                    if (cnt_q == STEP_LAST) begin
                        cnt_nxt = '0;
                        if (level_q != 4'd0) level_nxt = level_q - 4'd1;
                        else                 state_nxt = FADE_UP;
                    end else begin
                        cnt_nxt = cnt_q + CNT_ONE;
                    end
                end
                FADE_UP: begin
                    if (cnt_q == STEP_LAST) begin
                        cnt_nxt = '0;
                        if (level_q != 4'd15) level_nxt = level_q + 4'd1;
                        else                  state_nxt = HOLD;
                    end else begin
                        cnt_nxt = cnt_q + CNT_ONE;
                    end
                end
                HOLD: begin
                    if (cnt_q == HOLD_LAST) begin
                        cnt_nxt   = '0;
                        state_nxt = FADE_DOWN;
                    end else begin
                        cnt_nxt = cnt_q + CNT_ONE;
                    end
                end
                default: state_nxt = MANUAL;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_q      <= 4'd15;
            cnt_q        <= '0;
            color_q      <= 3'b111;
            dim_q        <= 4'd15;
            fade_q       <= 1'b0;
            pend_up_q    <= 1'b0;
            pend_down_q  <= 1'b0;
            pend_mode_q  <= 1'b0;
            pend_color_q <= 1'b0;
        end else if (bus.frame_start) begin
            level_q      <= level_nxt;
            cnt_q        <= cnt_nxt;
            color_q      <= req_color ? color_q + 3'd1 : color_q;
            dim_q        <= map_level(level_nxt);
            fade_q       <= (state_nxt != MANUAL);
            pend_up_q    <= 1'b0;
            pend_down_q  <= 1'b0;
            pend_mode_q  <= 1'b0;
            pend_color_q <= 1'b0;
        end else begin
            pend_up_q    <= req_up;
            pend_down_q  <= req_down;
            pend_mode_q  <= req_mode;
            pend_color_q <= req_color;
        end
    end

    assign bus.dim_level   = dim_q;
    assign bus.xhair_color = color_q;
    assign bus.fade_active = fade_q;

endmodule

// File: tb/tb_dim_sequencer.sv
// Randomized directed bench for dim_sequencer against a frame-level trajectory model.
module tb_dim_sequencer;
    localparam int FPS = 2;
    localparam int HF  = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dim_sequencer_if bus ();

    dim_sequencer #(.FRAMES_PER_STEP(FPS), .HOLD_FRAMES(HF)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int  n_assert = 0;
    int  n_fail   = 0;
    int  m_level;
    int  m_color;
    bit  m_manual;
    int  traj[$];
    bit  pu, pd, pm, pc;

    function automatic int exp_dim(int l);
`ifdef DIM_GAMMA_EN
        int g[16] = '{0, 0, 0, 1, 1, 1, 2, 2, 3, 4, 5, 6, 8, 10, 12, 15};
        return g[l];
`else
        return l;
`endif
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(string tag);
        chk({tag, ".dim"},    {28'd0, bus.dim_level},   exp_dim(m_level));
        chk({tag, ".color"},  {29'd0, bus.xhair_color}, m_color);
        chk({tag, ".active"}, {31'd0, bus.fade_active}, {31'd0, !m_manual});
    endtask

    // Per-frame levels of an auto run that starts in fade-down at level l0, ending after one hold.
    task automatic push_cycle(int l0);
        for (int l = l0; l > 0; l--) begin
            repeat (FPS - 1) traj.push_back(l);
            traj.push_back(l - 1);
        end
        repeat (FPS) traj.push_back(0);
        for (int l = 0; l < 15; l++) begin
            repeat (FPS - 1) traj.push_back(l);
            traj.push_back(l + 1);
        end
        repeat (FPS) traj.push_back(15);
        repeat (HF) traj.push_back(15);
    endtask

    task automatic model_reset();
        m_level  = 15;
        m_color  = 7;
        m_manual = 1'b1;
        traj.delete();
        {pu, pd, pm, pc} = 4'b0;
    endtask

    task automatic model_frame(bit u, bit d, bit m, bit c);
        if (c) m_color = (m_color + 1) % 8;
        if (m) begin
            traj.delete();
            if (m_manual) begin
                m_manual = 1'b0;
                push_cycle(m_level);
            end else begin
                m_manual = 1'b1;
            end
        end else if (m_manual) begin
            if (u && !d && m_level < 15)      m_level++;
            else if (d && !u && m_level > 0)  m_level--;
        end else begin
            if (traj.size() == 0) push_cycle(15);
            m_level = traj.pop_front();
        end
    endtask

    task automatic drive_idle();
        bus.btn_up      = 1'b0;
        bus.btn_down    = 1'b0;
        bus.btn_mode    = 1'b0;
        bus.btn_color   = 1'b0;
        bus.frame_start = 1'b0;
    endtask

    // Pulses the chosen buttons once (during the gap, or on the frame_start cycle when late=1).
    task automatic run_frame(string tag, bit u, bit d, bit m, bit c, int gap, bit late);
        int when;
        when = late ? gap : $urandom_range(0, gap - 1);
        for (int i = 0; i <= gap; i++) begin
            @(negedge clk);
            bus.btn_up      = (i == when) && u;
            bus.btn_down    = (i == when) && d;
            bus.btn_mode    = (i == when) && m;
            bus.btn_color   = (i == when) && c;
            bus.frame_start = (i == gap);
            if (i == gap) check_outputs({tag, ".pre"});
        end
        @(posedge clk);
        #1;
        drive_idle();
        model_frame(u | pu, d | pd, m | pm, c | pc);
        {pu, pd, pm, pc} = 4'b0;
        check_outputs(tag);
    endtask

    initial begin
        drive_idle();
        rst = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check_outputs("reset");

        repeat (3) run_frame("down", 0, 1, 0, 0, $urandom_range(1, 4), 1'($urandom_range(0, 1)));

        @(negedge clk);
        bus.btn_up = 1'b1;
        @(negedge clk);
        bus.btn_up = 1'b0;
        repeat (1000) @(negedge clk);
        check_outputs("no_frame_hold");
        pu = 1'b1;
        run_frame("pending_up", 0, 0, 0, 0, 2, 0);

        repeat (4) run_frame("up_sat", 1, 0, 0, 0, $urandom_range(1, 4), 1'($urandom_range(0, 1)));
        run_frame("up_down_same", 1, 1, 0, 0, 3, 0);
        run_frame("up_down_late", 1, 1, 0, 0, 2, 1);
        run_frame("down_one", 0, 1, 0, 0, 2, 0);
        run_frame("mode_up", 1, 0, 1, 0, 3, 0);

        for (int f = 0; f < 150; f++)
            run_frame("auto", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0,
                      1'($urandom_range(0, 1)), $urandom_range(1, 3), 1'($urandom_range(0, 1)));

        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_outputs("reset_mid_fade");
        @(negedge clk);
        rst = 1'b0;

        for (int k = 0; k < 9; k++)
            run_frame("color", 0, 0, 0, 1, $urandom_range(1, 3), 1'($urandom_range(0, 1)));

        for (int f = 0; f < 200; f++)
            run_frame("random", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)),
                      $urandom_range(1, 4), 1'($urandom_range(0, 1)));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
